// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory-busy freeze,
// with saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] REG_ZERO = 5'd0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RSaddr_i,
  input  logic [4:0]       ID_RTaddr_i,
  input  logic             ID_useRT_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RDaddr_i,
  input  logic             EX_BrTaken_i,
  input  logic             MEM_busy_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEXBubble_o,
  output logic             IFIDFlush_o,
  output logic             IDEXFreeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  state_e           state_p0;
  state_e           state_nxt;
  logic [CNT_W-1:0] stall_cnt_p0;
  logic [CNT_W-1:0] flush_cnt_p0;
  logic             hz;
  logic             br_en;
  logic             hz_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      return v;
  endfunction

  assign hz = EX_MemRead_i && (EX_RDaddr_i != REG_ZERO) &&
              ((EX_RDaddr_i == ID_RSaddr_i) ||
               (ID_useRT_i && (EX_RDaddr_i == ID_RTaddr_i)));

  // A bubble sits in EX during FLUSH, and the load has left EX during LOAD_STALL.
  always_comb begin
    br_en = 1'b1;
    hz_en = 1'b1;
    unique case (state_p0)
      RUN, MEM_WAIT: begin
        br_en = 1'b1;
        hz_en = 1'b1;
      end
      LOAD_STALL: begin
        br_en = 1'b1;
        hz_en = 1'b0;
      end
      FLUSH: begin
        br_en = 1'b0;
        hz_en = 1'b0;
      end
      default: begin
        br_en = 1'b1;
        hz_en = 1'b1;
      end
    endcase
  end

  always_comb begin
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IDEXBubble_o = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXFreeze_o = 1'b0;
    state_nxt    = RUN;
    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
    end else if (MEM_busy_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXFreeze_o = 1'b1;
      state_nxt    = MEM_WAIT;
    end else if (EX_BrTaken_i && br_en) begin
      IFIDFlush_o  = 1'b1;
      IDEXBubble_o = 1'b1;
      state_nxt    = FLUSH;
    end else if (hz && hz_en) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
      state_nxt    = LOAD_STALL;
    end
  end

  // Registered state and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0     <= RUN;
      stall_cnt_p0 <= '0;
      flush_cnt_p0 <= '0;
    end else begin
      state_p0     <= state_nxt;
      stall_cnt_p0 <= sat_inc(stall_cnt_p0, !PCWrite_o);
      flush_cnt_p0 <= sat_inc(flush_cnt_p0, IFIDFlush_o);
    end
  end

  assign state_o     = state_p0;
  assign stall_cnt_o = stall_cnt_p0;
  assign flush_cnt_o = flush_cnt_p0;

endmodule
